sobel_stream_param: RTL

Parametrised streaming 3x3 Sobel edge detector for raster-order grayscale pixels. Replaces the fixed-width basic Sobel stage in the image pipeline and adds configurable pixel width, frame height, gradient mode, output scaling, and end-of-frame flush. It emits exactly one output per input pixel, tagged with the output pixel's row/column coordinates. Border pixels are output as zero.

---
 rtl/sobel_stream_param.sv | 340 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sobel_stream_param.sv
// sobel_stream_param: streaming 3x3 Sobel edge detector for raster-order
// grayscale pixels. Two line buffers plus a 3x3 window feed a three-stage
// pipeline (window / gradients / magnitude). A FLUSH phase injects W+1 zero
// pixels after each frame so the last line's centers are emitted, then DONE
// clears the counters.
//
// Optional feature: define SOBEL_THRESH_EN to add the `thresh` input and
// binarise the output (all-ones if magnitude >= thresh, else zero).
//
// Handshake: a pixel is accepted on a rising edge where pixel_in_valid and
// pixel_in_ready are both high; while ready is low the source holds its pixel.
module sobel_stream_param #(
    parameter int DATA_W       = 8,
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int SHIFT        = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pixel_in_valid,
    input  logic [DATA_W-1:0]               pixel_in,
    output logic                            pixel_in_ready,
    input  logic [1:0]                      mode,
`ifdef SOBEL_THRESH_EN
    input  logic [DATA_W-1:0]               thresh,
`endif
    output logic                            pixel_out_valid,
    output logic [DATA_W-1:0]               pixel_out,
    output logic [$clog2(IMAGE_HEIGHT)-1:0] out_row,
    output logic [$clog2(IMAGE_WIDTH)-1:0]  out_col,
    output logic                            frame_done,
    output logic [1:0]                      dbg_state
);

    localparam int ROW_W  = $clog2(IMAGE_HEIGHT);
    localparam int COL_W  = $clog2(IMAGE_WIDTH);
    // Input row counter runs two lines past the frame during FLUSH.
    localparam int CNT_RW = $clog2(IMAGE_HEIGHT + 2);
    localparam int GW     = DATA_W + 3;
    localparam int MW     = DATA_W + 4;

    localparam logic [COL_W-1:0]  W_LAST    = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [CNT_RW-1:0] H_LAST    = CNT_RW'(IMAGE_HEIGHT - 1);
    localparam logic [CNT_RW-1:0] FLUSH_ROW = CNT_RW'(IMAGE_HEIGHT + 1);
    localparam logic [CNT_RW-1:0] ROW_ONE   = CNT_RW'(1);
    localparam logic [CNT_RW-1:0] ROW_TWO   = CNT_RW'(2);
    localparam logic [DATA_W-1:0] PIX_MAX   = {DATA_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [COL_W-1:0]  in_col_q, in_col_d;
    logic [CNT_RW-1:0] in_row_q, in_row_d;
    logic [1:0]        mode_q, mode_d;
`ifdef SOBEL_THRESH_EN
    logic [DATA_W-1:0] thresh_q, thresh_d;
`endif

    logic              step;
    logic [DATA_W-1:0] step_pix;

    // Line buffers: line0 holds the previous line, line1 the one before it.
    logic [DATA_W-1:0] line0_mem [IMAGE_WIDTH];
    logic [DATA_W-1:0] line1_mem [IMAGE_WIDTH];
    logic [DATA_W-1:0] line0_rd, line1_rd;

    // Window: win[row][col], row 0 = oldest line, col 2 = newest column.
    logic [DATA_W-1:0] win_q [3][3];
    logic [DATA_W-1:0] win_d [3][3];

    // Center bookkeeping for the current step.
    logic              emit;
    logic [CNT_RW-1:0] c_row;
    logic [COL_W-1:0]  c_col;
    logic              c_border, c_last;

    // S0 tags (travel with the window)
    logic              s0_valid_q, s0_valid_d;
    logic              s0_border_q, s0_border_d;
    logic              s0_last_q, s0_last_d;
    logic [ROW_W-1:0]  s0_row_q, s0_row_d;
    logic [COL_W-1:0]  s0_col_q, s0_col_d;

    // S1 gradients and tags
    logic signed [GW-1:0] gx_q, gx_d, gy_q, gy_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_border_q, s1_border_d;
    logic              s1_last_q, s1_last_d;
    logic [ROW_W-1:0]  s1_row_q, s1_row_d;
    logic [COL_W-1:0]  s1_col_q, s1_col_d;

    // S2 output registers
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_pix_q, out_pix_d;
    logic [ROW_W-1:0]  out_row_q, out_row_d;
    logic [COL_W-1:0]  out_col_q, out_col_d;
    logic              frame_done_q, frame_done_d;

    // FSM next state and step generation: RUN accepts, FLUSH injects zeros.
    always_comb begin
        state_d  = state_q;
        step     = 1'b0;
        step_pix = '0;
        case (state_q)
            ST_RUN: begin
                if (pixel_in_valid) begin
                    step     = 1'b1;
                    step_pix = pixel_in;
                    if (in_row_q == H_LAST && in_col_q == W_LAST) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                step = 1'b1;
                if (in_row_q == FLUSH_ROW) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Raster counters and per-frame mode/threshold capture at index 0.
    always_comb begin
        in_col_d = in_col_q;
        in_row_d = in_row_q;
        mode_d   = mode_q;
`ifdef SOBEL_THRESH_EN
        thresh_d = thresh_q;
`endif
        if (state_q == ST_DONE) begin
            in_col_d = '0;
            in_row_d = '0;
        end else if (step) begin
            if (in_col_q == W_LAST) begin
                in_col_d = '0;
                in_row_d = in_row_q + ROW_ONE;
            end else begin
                in_col_d = in_col_q + COL_W'(1);
            end
        end
        if (state_q == ST_RUN && step && in_row_q == '0 && in_col_q == '0) begin
            mode_d = mode;
`ifdef SOBEL_THRESH_EN
            thresh_d = thresh;
`endif
        end
    end

    // Center of the window completed by this step: index k-W-1.
    always_comb begin
        emit  = step && ((in_row_q >= ROW_TWO) || (in_row_q == ROW_ONE && in_col_q != '0));
        c_row = in_row_q - ROW_ONE;
        c_col = in_col_q - COL_W'(1);
        if (in_col_q == '0) begin
            c_row = in_row_q - ROW_TWO;
            c_col = W_LAST;
        end
        c_border = (c_row == '0) || (c_row == H_LAST) || (c_col == '0) || (c_col == W_LAST);
        c_last   = (c_row == H_LAST) && (c_col == W_LAST);
    end

    assign line0_rd = line0_mem[in_col_q];
    assign line1_rd = line1_mem[in_col_q];

    // Window shift left by one column, new column from line buffers + pixel.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_d[r][c] = win_q[r][c];
            end
        end
        if (step) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = line1_rd;
            win_d[1][2] = line0_rd;
            win_d[2][2] = step_pix;
        end
        s0_valid_d  = emit;
        s0_border_d = s0_border_q;
        s0_last_d   = s0_last_q;
        s0_row_d    = s0_row_q;
        s0_col_d    = s0_col_q;
        if (emit) begin
            s0_border_d = c_border;
            s0_last_d   = c_last;
            s0_row_d    = c_row[ROW_W-1:0];
            s0_col_d    = c_col;
        end
    end

    // Line-buffer RAM: not reset; stale contents only reach border outputs.
    always_ff @(posedge clk) begin
        if (step) begin
            line0_mem[in_col_q] <= step_pix;
            line1_mem[in_col_q] <= line0_rd;
        end
    end

    // S1: signed horizontal and vertical gradients.
    always_comb begin
        logic signed [GW-1:0] w [3][3];
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w[r][c] = $signed({3'b000, win_q[r][c]});
            end
        end
        gx_d = (w[0][2] + w[1][2] + w[1][2] + w[2][2])
             - (w[0][0] + w[1][0] + w[1][0] + w[2][0]);
        gy_d = (w[2][0] + w[2][1] + w[2][1] + w[2][2])
             - (w[0][0] + w[0][1] + w[0][1] + w[0][2]);
        s1_valid_d  = s0_valid_q;
        s1_border_d = s0_border_q;
        s1_last_d   = s0_last_q;
        s1_row_d    = s0_row_q;
        s1_col_d    = s0_col_q;
    end

    // S2: abs, mode combine, shift, saturate, optional threshold, border zero.
    always_comb begin
        logic signed [GW-1:0] ngx, ngy;
        logic [MW-1:0]        ax, ay, mag, shifted;
        logic [DATA_W-1:0]    sat, res;
        ngx = -gx_q;
        ngy = -gy_q;
        ax  = {1'b0, (gx_q[GW-1] ? ngx : gx_q)};
        ay  = {1'b0, (gy_q[GW-1] ? ngy : gy_q)};
        case (mode_q)
            2'd0:    mag = ax + ay;
            2'd1:    mag = ax;
            2'd2:    mag = ay;
            default: mag = (ax >= ay) ? ax : ay;
        endcase
        shifted = mag >> SHIFT;
        sat     = (shifted > {4'b0000, PIX_MAX}) ? PIX_MAX : shifted[DATA_W-1:0];
`ifdef SOBEL_THRESH_EN
        res = (sat >= thresh_q) ? PIX_MAX : '0;
`else
        res = sat;
`endif
        if (s1_border_q) begin
            res = '0;
        end
        out_valid_d  = s1_valid_q;
        out_pix_d    = out_pix_q;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        frame_done_d = 1'b0;
        if (s1_valid_q) begin
            out_pix_d    = res;
            out_row_d    = s1_row_q;
            out_col_d    = s1_col_q;
            frame_done_d = s1_last_q;
        end
    end

    // All state registers; reset drops in-flight pipeline valids.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            in_col_q     <= '0;
            in_row_q     <= '0;
            mode_q       <= '0;
`ifdef SOBEL_THRESH_EN
            thresh_q     <= '0;
`endif
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            s0_valid_q   <= 1'b0;
            s0_border_q  <= 1'b0;
            s0_last_q    <= 1'b0;
            s0_row_q     <= '0;
            s0_col_q     <= '0;
            gx_q         <= '0;
            gy_q         <= '0;
            s1_valid_q   <= 1'b0;
            s1_border_q  <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_row_q     <= '0;
            s1_col_q     <= '0;
            out_valid_q  <= 1'b0;
            out_pix_q    <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_col_q     <= in_col_d;
            in_row_q     <= in_row_d;
            mode_q       <= mode_d;
`ifdef SOBEL_THRESH_EN
            thresh_q     <= thresh_d;
`endif
            win_q        <= win_d;
            s0_valid_q   <= s0_valid_d;
            s0_border_q  <= s0_border_d;
            s0_last_q    <= s0_last_d;
            s0_row_q     <= s0_row_d;
            s0_col_q     <= s0_col_d;
            gx_q         <= gx_d;
            gy_q         <= gy_d;
            s1_valid_q   <= s1_valid_d;
            s1_border_q  <= s1_border_d;
            s1_last_q    <= s1_last_d;
            s1_row_q     <= s1_row_d;
            s1_col_q     <= s1_col_d;
            out_valid_q  <= out_valid_d;
            out_pix_q    <= out_pix_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pixel_in_ready  = (state_q == ST_RUN);
    assign pixel_out_valid = out_valid_q;
    assign pixel_out       = out_pix_q;
    assign out_row         = out_row_q;
    assign out_col         = out_col_q;
    assign frame_done      = frame_done_q;
    assign dbg_state       = state_q;

endmodule
